// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display path:
//   state_t            loader state machine encoding {HUNT, B0, B1, B2, DONE}
//   PIX_W              pixel width (RGB444). The display_controller uses the same constant.
//   SYNC_BYTE_DEFAULT  default frame start marker
//   R/G/B_MSB/LSB      field positions inside a {R,G,B} pixel
// No ports (package).
// -----------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int PIX_W = 12;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

endpackage

// File: rtl/pixel_stream_loader_if.sv
// -----------------------------------------------------------------------------
// pixel_stream_loader_if
// Groups the byte-stream handshake and the frame-buffer write port of the
// pixel stream loader.
//   in_data    [7:0]         stream byte
//   in_valid                 in_data valid
//   in_ready                 loader accepts in_data this cycle
//   write_addr [ADDR_W-1:0]  frame-buffer address
//   w_en                     write strobe
//   pixel_out  [PIX_W-1:0]   pixel {R,G,B}
//   frame_done               pulse with the write to the last address
//   frame_err                pulse on a mid-frame timeout abort
// Modports: master = stream source / frame-buffer side, slave = loader.
// -----------------------------------------------------------------------------
interface pixel_stream_loader_if
  import display_pkg::*;
#(
  parameter int ADDR_W = 12
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] write_addr;
  logic              w_en;
  logic [PIX_W-1:0]  pixel_out;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, write_addr, w_en, pixel_out, frame_done, frame_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, write_addr, w_en, pixel_out, frame_done, frame_err
  );

endinterface

// File: rtl/rgb444_unpacker.sv
// -----------------------------------------------------------------------------
// rgb444_unpacker
// Combinational 3-byte -> 2-pixel splitter. Bytes b0,b1,b2 carry the pixels
// {b0, b1[7:4]} and {b1[3:0], b2}.
//   i_phase      0: first pixel of the pair, 1: second pixel
//   i_hold_byte  held b0 (used in phase 0)
//   i_hold_nib   held b1[3:0] (used in phase 1)
//   i_byte       byte being accepted (b1 in phase 0, b2 in phase 1)
//   o_pixel      assembled {R,G,B}
//   o_hold_nib   low nibble of i_byte, to be held for phase 1
// -----------------------------------------------------------------------------
module rgb444_unpacker
  import display_pkg::*;
(
  input  logic             i_phase,
  input  logic [7:0]       i_hold_byte,
  input  logic [3:0]       i_hold_nib,
  input  logic [7:0]       i_byte,
  output logic [PIX_W-1:0] o_pixel,
  output logic [3:0]       o_hold_nib
);

  always_comb begin
    o_pixel = '0;
    if (!i_phase) begin
      o_pixel[R_MSB:R_LSB] = i_hold_byte[7:4];
      o_pixel[G_MSB:G_LSB] = i_hold_byte[3:0];
      o_pixel[B_MSB:B_LSB] = i_byte[7:4];
    end else begin
      o_pixel[R_MSB:R_LSB] = i_hold_nib;
      o_pixel[G_MSB:G_LSB] = i_byte[7:4];
      o_pixel[B_MSB:B_LSB] = i_byte[3:0];
    end
  end

  assign o_hold_nib = i_byte[3:0];

endmodule

// File: rtl/pixel_stream_loader.sv
// -----------------------------------------------------------------------------
// pixel_stream_loader
// Converts a byte stream (sync byte followed by a full frame of RGB444 pixels,
// 2 pixels per 3 bytes) into linear frame-buffer writes for display_controller.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    pixel_stream_loader_if.slave: in_data/in_valid/in_ready stream,
//          write_addr/w_en/pixel_out write port, frame_done, frame_err
// Optional build macro LOADER_TIMEOUT_EN: adds a mid-frame idle counter that
// aborts to HUNT after TIMEOUT_CYCLES idle cycles and pulses frame_err.
// Without it frame_err is constant 0 and a stalled frame waits indefinitely.
// -----------------------------------------------------------------------------
module pixel_stream_loader
  import display_pkg::*;
#(
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pixel_stream_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t             r_state;
  state_t             w_next_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_h0;
  logic [3:0]         r_h1;
  logic               r_in_ready;
  logic               r_w_en;
  logic [ADDR_W-1:0]  r_write_addr;
  logic [PIX_W-1:0]   r_pixel;
  logic               r_frame_done;

  logic               w_accept;
  logic               w_write;
  logic               w_last;
  logic               w_phase;
  logic               w_timeout;
  logic [PIX_W-1:0]   w_pixel;
  logic [3:0]         w_low_nib;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_last   = (r_addr == LAST_ADDR);
  assign w_phase  = (r_state == B2);

  rgb444_unpacker u_unpacker (
    .i_phase     (w_phase),
    .i_hold_byte (r_h0),
    .i_hold_nib  (r_h1),
    .i_byte      (bus.in_data),
    .o_pixel     (w_pixel),
    .o_hold_nib  (w_low_nib)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] r_idle;
  logic              r_frame_err;
  logic              w_in_frame;

  assign w_in_frame = (r_state == B0) || (r_state == B1) || (r_state == B2);
  // An accepted byte always wins over the timeout on the same edge.
  assign w_timeout  = w_in_frame && !w_accept && (r_idle == IDLE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (!w_in_frame || w_accept) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + IDLE_W'(1);
      end
      r_frame_err <= w_timeout;
    end
  end

  assign bus.frame_err = r_frame_err;
`else
  assign w_timeout     = 1'b0;
  assign bus.frame_err = 1'b0;
`endif

  // Next-state and write decode
  always_comb begin
    w_next_state = r_state;
    w_write      = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (w_accept && (bus.in_data == SYNC_BYTE)) begin
          w_next_state = B0;
        end
      end
      B0: begin
        if (w_accept) begin
          w_next_state = B1;
        end
      end
      B1: begin
        if (w_accept) begin
          w_next_state = B2;
          w_write      = 1'b1;
        end
      end
      B2: begin
        if (w_accept) begin
          w_next_state = w_last ? DONE : B0;
          w_write      = 1'b1;
        end
      end
      DONE:    w_next_state = HUNT;
      default: w_next_state = HUNT;
    endcase
    // Timeout only fires when nothing is accepted, so w_write is already 0.
    if (w_timeout) begin
      w_next_state = HUNT;
    end
  end

  // State register; in_ready is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != DONE);
    end
  end

  // Address counter and partial-pixel holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_h0   <= '0;
      r_h1   <= '0;
    end else begin
      if ((r_state == HUNT) && (w_next_state == B0)) begin
        r_addr <= '0;
      end else if (w_write) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if ((r_state == B0) && w_accept) begin
        r_h0 <= bus.in_data;
      end
      if ((r_state == B1) && w_accept) begin
        r_h1 <= w_low_nib;
      end
    end
  end

  // Registered write port: address and pixel hold between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_en       <= 1'b0;
      r_write_addr <= '0;
      r_pixel      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_w_en       <= w_write;
      r_frame_done <= w_write && (r_state == B2) && w_last;
      if (w_write) begin
        r_write_addr <= r_addr;
        r_pixel      <= w_pixel;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.w_en       = r_w_en;
  assign bus.write_addr = r_write_addr;
  assign bus.pixel_out  = r_pixel;
  assign bus.frame_done = r_frame_done;

endmodule
